// File: rtl/run_watchdog_pkg.sv
// Shared types and constants for the run watchdog and its stall detector.
package run_watchdog_pkg;

    // Run controller states; encoding is visible to debug paths, so it is fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_MAX_CYCLES  = 500;
    localparam int unsigned DEFAULT_STALL_LIMIT = 16;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_watchdog_stall.sv
// Detects a stuck PC: flags the valid sample at which the run of repeated
// PC values would reach STALL_LIMIT. Invalid samples leave all state alone.
module pc_stall_detector
    import run_watchdog_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic [PC_W-1:0] pc,
    input  logic            pc_valid,
    output logic            stall_hit,
    output logic [PC_W-1:0] last_pc
);

    localparam int unsigned     SW     = cnt_width(STALL_LIMIT);
    localparam logic [SW-1:0]   HIT_AT = (STALL_LIMIT > 0) ? SW'(STALL_LIMIT - 1) : '0;

    logic [SW-1:0]   r_stall_cnt;
    logic [PC_W-1:0] r_last_pc;
    logic            r_last_valid;
    logic            w_same;

    assign w_same    = pc_valid && r_last_valid && (pc == r_last_pc);
    assign stall_hit = (STALL_LIMIT != 0) && w_same && (r_stall_cnt == HIT_AT);
    assign last_pc   = r_last_pc;

    // Track the last valid PC and how many times in a row it has repeated.
    // The counter saturates one short of the limit; the hit itself ends the run.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_stall_cnt  <= '0;
            r_last_pc    <= '0;
            r_last_valid <= 1'b0;
        end else if (pc_valid) begin
            if (!r_last_valid) begin
                r_last_pc    <= pc;
                r_last_valid <= 1'b1;
                r_stall_cnt  <= '0;
            end else if (pc == r_last_pc) begin
                if (r_stall_cnt != HIT_AT)
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_stall_cnt <= '0;
                r_last_pc   <= pc;
            end
        end
    end

endmodule

// File: rtl/run_watchdog.sv
// Run controller: holds the processor in reset, releases it, counts run
// cycles and stops on a cycle budget or a stuck PC, latching the results.
module run_watchdog
    import run_watchdog_pkg::*;
#(
    parameter int unsigned CYCLE_W      = 32,
    parameter int unsigned PC_W         = 32,
    parameter int unsigned MAX_CYCLES   = DEFAULT_MAX_CYCLES,
    parameter int unsigned STALL_LIMIT  = DEFAULT_STALL_LIMIT,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    pc,
    input  logic               pc_valid,
    output logic               proc_reset,
    output logic               running,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               timeout,
    output logic               halted,
    output logic               done,
    output logic [PC_W-1:0]    final_pc
);

    localparam int unsigned        HW         = cnt_width(RESET_CYCLES);
    localparam logic [HW-1:0]      HOLD_LOAD  = (RESET_CYCLES > 0) ? HW'(RESET_CYCLES - 1) : '0;
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = (MAX_CYCLES > 0) ? CYCLE_W'(MAX_CYCLES - 1) : '0;

    state_t             r_state;
    logic [HW-1:0]      r_hold_cnt;
    logic               r_proc_reset;
    logic               r_running;
    logic [CYCLE_W-1:0] r_cycle_count;
    logic               r_timeout;
    logic               r_halted;
    logic               r_done;

    logic               w_in_run;
    logic               w_sample_valid;
    logic               w_restart;
    logic               w_stall_hit;
    logic               w_timeout_hit;
    logic [CYCLE_W-1:0] w_cycle_next;
    logic [PC_W-1:0]    w_last_pc;

    assign w_in_run       = (r_state == ST_RUN);
    assign w_sample_valid = w_in_run && pc_valid;
    assign w_restart      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_timeout_hit  = (MAX_CYCLES != 0) && w_in_run && (r_cycle_count == LAST_CYCLE);
    assign w_cycle_next   = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 1'b1;

    // PC samples only count while the processor is actually running.
    pc_stall_detector #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_restart),
        .pc        (pc),
        .pc_valid  (w_sample_valid),
        .stall_hit (w_stall_hit),
        .last_pc   (w_last_pc)
    );

    // Run FSM with registered outputs; a start from IDLE or DONE clears the
    // previous run's results on the same edge that enters HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_proc_reset  <= 1'b1;
            r_running     <= 1'b0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_halted      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_proc_reset <= 1'b1;
                    r_running    <= 1'b0;
                    if (start) begin
                        r_state       <= ST_HOLD;
                        r_hold_cnt    <= HOLD_LOAD;
                        r_cycle_count <= '0;
                        r_timeout     <= 1'b0;
                        r_halted      <= 1'b0;
                        r_done        <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state      <= ST_RUN;
                        r_proc_reset <= 1'b0;
                        r_running    <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cycle_count <= w_cycle_next;
                    if (w_timeout_hit || w_stall_hit) begin
                        r_state      <= ST_DONE;
                        r_running    <= 1'b0;
                        r_proc_reset <= 1'b1;
                        r_done       <= 1'b1;
                        r_timeout    <= w_timeout_hit;
                        r_halted     <= w_stall_hit;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign proc_reset  = r_proc_reset;
    assign running     = r_running;
    assign cycle_count = r_cycle_count;
    assign timeout     = r_timeout;
    assign halted      = r_halted;
    assign done        = r_done;
    assign final_pc    = w_last_pc;

endmodule

// File: tb/tb_run_watchdog.sv
// Self-checking bench for run_watchdog: directed runs on three parameter
// sets plus randomized PC streams checked against a run-length model.
module tb_run_watchdog;

    localparam int unsigned C_MAX   = 64;
    localparam int unsigned C_STALL = 4;

    logic        clock;
    logic        reset;
    logic        start_a, start_b, start_c;
    logic [31:0] pc;
    logic        pc_valid;

    logic        a_proc_reset, a_running, a_timeout, a_halted, a_done;
    logic [31:0] a_cycle_count, a_final_pc;
    logic        b_proc_reset, b_running, b_timeout, b_halted, b_done;
    logic [31:0] b_cycle_count, b_final_pc;
    logic        c_proc_reset, c_running, c_timeout, c_halted, c_done;
    logic [31:0] c_cycle_count, c_final_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] stim_pc[$];
    bit          stim_v[$];

    run_watchdog #(.MAX_CYCLES(8), .STALL_LIMIT(4), .RESET_CYCLES(4)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .pc(pc), .pc_valid(pc_valid),
        .proc_reset(a_proc_reset), .running(a_running), .cycle_count(a_cycle_count),
        .timeout(a_timeout), .halted(a_halted), .done(a_done), .final_pc(a_final_pc)
    );

    run_watchdog #(.MAX_CYCLES(5), .STALL_LIMIT(4), .RESET_CYCLES(2)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .pc(pc), .pc_valid(pc_valid),
        .proc_reset(b_proc_reset), .running(b_running), .cycle_count(b_cycle_count),
        .timeout(b_timeout), .halted(b_halted), .done(b_done), .final_pc(b_final_pc)
    );

    run_watchdog #(.MAX_CYCLES(C_MAX), .STALL_LIMIT(C_STALL), .RESET_CYCLES(3)) u_dut_c (
        .clock(clock), .reset(reset), .start(start_c), .pc(pc), .pc_valid(pc_valid),
        .proc_reset(c_proc_reset), .running(c_running), .cycle_count(c_cycle_count),
        .timeout(c_timeout), .halted(c_halted), .done(c_done), .final_pc(c_final_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a run ends at the first RUN cycle where either the budget is
    // used up or the current valid PC is the (STALL+1)-th identical valid
    // sample in a row (invalid samples neither extend nor break the run).
    function automatic void model(input int unsigned max_c, input int unsigned stall,
                                  output int end_i, output bit to, output bit ha,
                                  output logic [31:0] fpc);
        int          len;
        bit          have;
        logic [31:0] prev;
        bit          v;
        logic [31:0] p;
        len = 0; have = 0; prev = '0; fpc = '0; to = 0; ha = 0; end_i = -1;
        for (int i = 0; i < 1000; i++) begin
            v = (i < stim_v.size()) ? stim_v[i] : 1'b0;
            p = (i < stim_pc.size()) ? stim_pc[i] : 32'd0;
            if (v) begin
                len  = (have && p == prev) ? len + 1 : 1;
                prev = p;
                have = 1;
                fpc  = p;
            end
            to = (max_c != 0) && (i == int'(max_c) - 1);
            ha = (stall != 0) && v && (len == int'(stall) + 1);
            if (to || ha) begin
                end_i = i;
                return;
            end
        end
    endfunction

    // One run on instance A with an incrementing PC; must end on the budget.
    task automatic run_a_timeout(input string tag);
        int          hold;
        int          run;
        logic [31:0] exp_final;
        exp_final = '0;
        pc_valid = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, "_start_done"}, a_done, 0);
        chk({tag, "_start_count"}, a_cycle_count, 0);
        chk({tag, "_start_timeout"}, a_timeout, 0);
        chk({tag, "_start_halted"}, a_halted, 0);
        hold = 0;
        while (a_proc_reset === 1'b1 && hold < 32) begin
            hold++;
            tick();
        end
        chk({tag, "_hold_len"}, hold, 4);
        run = 0;
        while (a_running === 1'b1 && run < 32) begin
            if (run == 0) chk({tag, "_first_count"}, a_cycle_count, 0);
            pc = pc + 32'd4;
            exp_final = pc;
            tick();
            run++;
        end
        chk({tag, "_run_len"}, run, 8);
        chk({tag, "_done"}, a_done, 1);
        chk({tag, "_timeout"}, a_timeout, 1);
        chk({tag, "_halted"}, a_halted, 0);
        chk({tag, "_count"}, a_cycle_count, 8);
        chk({tag, "_final_pc"}, a_final_pc, exp_final);
        chk({tag, "_proc_reset"}, a_proc_reset, 1);
    endtask

    // One run on instance C driven from the stimulus queues, checked per cycle.
    task automatic run_c(input string tag);
        int          exp_end;
        bit          exp_to;
        bit          exp_ha;
        logic [31:0] exp_fpc;
        int          hold;
        int          i;
        model(C_MAX, C_STALL, exp_end, exp_to, exp_ha, exp_fpc);
        pc_valid = 1'b0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk({tag, "_start_done"}, c_done, 0);
        chk({tag, "_start_count"}, c_cycle_count, 0);
        hold = 0;
        while (c_proc_reset === 1'b1 && hold < 32) begin
            hold++;
            tick();
        end
        chk({tag, "_hold_len"}, hold, 3);
        i = 0;
        while (c_running === 1'b1 && i < 200) begin
            chk({tag, "_cycle"}, c_cycle_count, i);
            pc_valid = (i < stim_v.size()) ? stim_v[i] : 1'b0;
            pc = (i < stim_pc.size()) ? stim_pc[i] : 32'd0;
            tick();
            i++;
        end
        pc_valid = 1'b0;
        chk({tag, "_run_len"}, i, exp_end + 1);
        chk({tag, "_done"}, c_done, 1);
        chk({tag, "_timeout"}, c_timeout, exp_to);
        chk({tag, "_halted"}, c_halted, exp_ha);
        chk({tag, "_count"}, c_cycle_count, exp_end + 1);
        chk({tag, "_final_pc"}, c_final_pc, exp_fpc);
    endtask

    int run;
    int hold;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pc = '0; pc_valid = 1'b0;

        // Reset hold and idle behaviour.
        tick();
        tick();
        chk("rst_proc_reset", a_proc_reset, 1);
        chk("rst_running", a_running, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_halted", a_halted, 0);
        chk("rst_final_pc", a_final_pc, 0);
        chk("rst_b_proc_reset", b_proc_reset, 1);
        chk("rst_c_done", c_done, 0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_proc_reset", a_proc_reset, 1);
            chk("idle_done", a_done, 0);
            chk("idle_count", a_cycle_count, 0);
        end

        // Budget-limited run.
        run_a_timeout("to1");

        // Stuck PC from the first RUN cycle; a start pulse mid-run is ignored.
        pc = 32'h40;
        pc_valid = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("halt_restart_done", a_done, 0);
        chk("halt_restart_timeout", a_timeout, 0);
        chk("halt_restart_count", a_cycle_count, 0);
        chk("halt_restart_proc_reset", a_proc_reset, 1);
        hold = 0;
        while (a_proc_reset === 1'b1 && hold < 32) begin
            hold++;
            tick();
        end
        chk("halt_hold_len", hold, 4);
        run = 0;
        while (a_running === 1'b1 && run < 32) begin
            start_a = (run == 2);
            tick();
            run++;
        end
        start_a = 1'b0;
        chk("halt_run_len", run, 5);
        chk("halt_halted", a_halted, 1);
        chk("halt_timeout", a_timeout, 0);
        chk("halt_final_pc", a_final_pc, 32'h40);
        chk("halt_count", a_cycle_count, 5);

        // Second budget run after a restart must match the first.
        pc = '0;
        run_a_timeout("to2");

        // Reset in the middle of a run.
        pc_valid = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        hold = 0;
        while (a_proc_reset === 1'b1 && hold < 32) begin
            hold++;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            pc = pc + 32'd4;
            tick();
        end
        chk("mid_count_before", a_cycle_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_proc_reset", a_proc_reset, 1);
        chk("mid_running", a_running, 0);
        chk("mid_count", a_cycle_count, 0);
        chk("mid_timeout", a_timeout, 0);
        chk("mid_halted", a_halted, 0);
        chk("mid_done", a_done, 0);
        chk("mid_final_pc", a_final_pc, 0);
        tick();
        chk("mid_idle_running", a_running, 0);
        chk("mid_idle_proc_reset", a_proc_reset, 1);

        // Budget and stall terminate on the same edge.
        pc = 32'h80;
        pc_valid = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        hold = 0;
        while (b_proc_reset === 1'b1 && hold < 32) begin
            hold++;
            tick();
        end
        chk("both_hold_len", hold, 2);
        run = 0;
        while (b_running === 1'b1 && run < 32) begin
            tick();
            run++;
        end
        chk("both_run_len", run, 5);
        chk("both_timeout", b_timeout, 1);
        chk("both_halted", b_halted, 1);
        chk("both_count", b_cycle_count, 5);
        chk("both_final_pc", b_final_pc, 32'h80);
        pc_valid = 1'b0;

        // Repeats separated by invalid gaps; counter restarts on a new PC.
        stim_pc = {32'h10, 32'h0, 32'h10, 32'h0, 32'h14, 32'h14, 32'h0, 32'h14, 32'h0, 32'h0,
                   32'h14, 32'h14};
        stim_v  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                   1'b1, 1'b1};
        run_c("gap");
        chk("gap_halted_direct", c_halted, 1);
        chk("gap_count_direct", c_cycle_count, 12);

        // Randomized PC streams; small alphabets tend to halt, large ones time out.
        for (int k = 0; k < 8; k++) begin
            int unsigned alpha;
            alpha = (k % 2 == 1) ? 32'd2 : ((k == 4) ? 32'd1 : 32'd100000);
            stim_pc.delete();
            stim_v.delete();
            for (int j = 0; j < 70; j++) begin
                stim_v.push_back($urandom_range(0, 3) != 0);
                stim_pc.push_back($urandom_range(0, alpha - 1) * 4);
            end
            run_c("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
